// File: rtl/sr_pulse_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one SR latch.
// Each grant drives s or r for PULSE_W cycles, waits GUARD_W settle
// cycles, then checks the latch feedback and pulses done (and err).
module sr_pulse_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GUARD_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op,
  input  logic             q_fb,
  output logic             s,
  output logic             r,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_MAX = (PULSE_W > GUARD_W) ? PULSE_W : GUARD_W;
  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, GUARD, CHECK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [PTR_W-1:0] win, win_nxt;
  logic             op_q, op_q_nxt;
  logic             s_nxt, r_nxt, busy_nxt, done_nxt, err_nxt;
  logic [N_REQ-1:0] gnt_nxt;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W:0]   scan_sum;
  logic [PTR_W:0]   ptr_inc;

  // Round-robin search upward from ptr, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      scan_sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (scan_sum >= (PTR_W+1)'(N_REQ)) begin
        scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
      end
      if (!win_found && req[scan_sum[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_sum[PTR_W-1:0];
      end
    end
  end

  // Pointer value following the current winner, wrapped modulo N_REQ.
  always_comb begin
    ptr_inc = {1'b0, win} + (PTR_W+1)'(1);
    if (ptr_inc >= (PTR_W+1)'(N_REQ)) begin
      ptr_inc = '0;
    end
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    win_nxt   = win;
    op_q_nxt  = op_q;
    s_nxt     = 1'b0;
    r_nxt     = 1'b0;
    gnt_nxt   = '0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt        = DRIVE;
          cnt_nxt          = '0;
          win_nxt          = win_idx;
          op_q_nxt         = op[win_idx];
          gnt_nxt[win_idx] = 1'b1;
          s_nxt            = op[win_idx];
          r_nxt            = ~op[win_idx];
        end
      end
      DRIVE: begin
        if (cnt == CNT_W'(PULSE_W - 1)) begin
          cnt_nxt = '0;
          if (GUARD_W == 0) begin
            state_nxt = CHECK;
            done_nxt  = 1'b1;
            err_nxt   = (q_fb != op_q);
          end else begin
            state_nxt = GUARD;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          s_nxt   = op_q;
          r_nxt   = ~op_q;
        end
      end
      GUARD: begin
        if (cnt == CNT_W'(GUARD_W - 1)) begin
          cnt_nxt   = '0;
          state_nxt = CHECK;
          done_nxt  = 1'b1;
          err_nxt   = (q_fb != op_q);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        ptr_nxt   = ptr_inc[PTR_W-1:0];
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers; reset aborts any operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      win   <= '0;
      op_q  <= 1'b0;
      s     <= 1'b0;
      r     <= 1'b0;
      gnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      win   <= win_nxt;
      op_q  <= op_q_nxt;
      s     <= s_nxt;
      r     <= r_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: doc/sr_pulse_arbiter.md
SR_PULSE_ARBITER -- requirements
Module: sr_pulse_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one SR latch; legal range 2..8.
REQ-002 Parameter PULSE_W, default 2: set/reset drive width in cycles; PULSE_W SHALL be >= 1.
REQ-003 Parameter GUARD_W, default 1: settle cycles after drive; 0 is legal.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 req  in  N_REQ  per-requester request, level; held until granted.
REQ-007 op  in  N_REQ  per-requester operation: 1 = set latch, 0 = reset latch.
REQ-008 q_fb  in  1  latch q output, fed back for confirmation.
REQ-009 s  out  1  latch set drive.
REQ-010 r  out  1  latch reset drive.
REQ-011 gnt  out  N_REQ  one-hot grant, high for exactly one cycle per accepted request.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse at completion of each operation.
REQ-014 err  out  1  one-cycle pulse, coincident with done, when q_fb mismatches the requested op.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 FSM states SHALL be IDLE, DRIVE, GUARD, CHECK.
REQ-017 IDLE: if req != 0, winner SHALL be chosen round-robin, searching upward from pointer ptr with wrap. On the next edge, winner index and op[winner] SHALL be captured and the FSM SHALL enter DRIVE.
REQ-018 gnt[winner] SHALL be high during the first DRIVE cycle only.
REQ-019 DRIVE SHALL last PULSE_W cycles, with s = captured op and r = ~captured op.
REQ-020 s and r SHALL never be 1 in the same cycle, including across state transitions and reset.
REQ-021 GUARD SHALL last GUARD_W cycles with s = r = 0. If GUARD_W = 0, DRIVE SHALL go directly to CHECK.
REQ-022 CHECK SHALL last one cycle with s = r = 0 and done = 1.
REQ-023 In CHECK, err SHALL be 1 iff q_fb != captured op.
REQ-024 In CHECK, ptr SHALL become (winner+1) mod N_REQ; the FSM SHALL return to IDLE.
REQ-025 ptr SHALL advance regardless of err.
REQ-026 Latency: req seen in IDLE at cycle 0 -> gnt and first s/r drive at cycle 1 -> done at cycle 1+PULSE_W+GUARD_W.
REQ-027 Minimum grant spacing SHALL be PULSE_W+GUARD_W+2 cycles.
REQ-028 req and op SHALL be sampled only in IDLE. Changes while busy SHALL have no effect on the operation in flight.
REQ-029 A req deasserted before being sampled in IDLE SHALL never be granted.
REQ-030 A req still high in IDLE after its own grant SHALL be treated as a new request, subject to round-robin order.
REQ-031 ptr SHALL be clog2(N_REQ) bits wide; the index search SHALL wrap modulo N_REQ.
REQ-032 The DRIVE and GUARD cycle counters SHALL be sized to hold max(PULSE_W, GUARD_W).

Reset
REQ-033 While rst_n = 0, the block SHALL be in the following state, taking effect immediately without waiting for clk:
- state = IDLE
- ptr = 0
- counters = 0
- s = 0, r = 0
- gnt = 0
- busy = 0, done = 0, err = 0
REQ-034 Reset asserted mid-operation (any non-IDLE state) SHALL abort it: no done, no err, s and r drop to 0 immediately.
REQ-035 After rst_n rises, the first arbitration SHALL start from requester 0.

Verification (N_REQ=4, PULSE_W=2, GUARD_W=1)
REQ-036 Single request: req=4'b0100, op[2]=1 at cycle 0, q_fb rises at cycle 2 -> required response:
- gnt=4'b0100 at cycle 1
- s=1 at cycles 1-2, r=0 throughout
- s=r=0 at cycle 3
- done=1, err=0 at cycle 4
- busy=0 at cycle 5
REQ-037 Full contention: req=4'b1111 held from cycle 0 -> grants in order 0,1,2,3,0 at cycles 1,6,11,16,21; gnt always one-hot.
REQ-038 Mismatch: op[0]=0 with q_fb stuck at 1 -> r=1 for 2 cycles, then done=1 and err=1 in the same cycle; next grant goes to requester 1 if pending.
REQ-039 Reset mid-drive: rst_n=0 during the second DRIVE cycle -> s=r=0, busy=0, gnt=0 before the next edge, no done. After release with req=4'b1010, gnt=4'b0010 first.
REQ-040 Missed request: req[3] pulsed for 1 cycle while busy, then low -> never granted; no done attributed to it.
REQ-041 Safety: over 10k cycles of random req/op/q_fb with random resets, a checker SHALL confirm:
- s & r never both 1
- gnt one-hot or zero
- done count = gnt count minus operations aborted by reset
